actuator_trigger_sequencer: RTL and testbench

- Sequences the eight actuator drive lines (DRV, PSG_Front, PSG_BackL, PSG_BackR; each with an Up and a Down line) from AVR-issued trigger commands.
- Only one actuator line is ever driven at a time, for an exact number of clock cycles.
- A mandatory dead-time follows every drive, so no two drive pulses are ever back-to-back.
- Sits between the AVR command decoder and the FPGA output pins; ready_out tells the AVR when a new command can be accepted.

---
 rtl/actuator_trigger_sequencer.sv | 131 +++++++++++++
 tb/tb_actuator_trigger_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/actuator_trigger_sequencer.sv
// Actuator trigger sequencer: drives one of eight actuator lines for an exact
// number of cycles per accepted command, then enforces a dead-time before the next one.
module actuator_trigger_sequencer #(
  parameter int LEN_W     = 16,
  parameter int DEAD_TIME = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_target,
  input  logic             cmd_dir,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             abort,
  output logic             ready_out,
  output logic             DRV_Up_Out,
  output logic             DRV_Down_Out,
  output logic             PSG_Front_Up_Out,
  output logic             PSG_Front_Down_Out,
  output logic             PSG_BackL_Up_Out,
  output logic             PSG_BackL_Down_Out,
  output logic             PSG_BackR_Up_Out,
  output logic             PSG_BackR_Down_Out,
  output logic             done,
  output logic             aborted
);

  localparam int DEAD_W = (DEAD_TIME < 2) ? 1 : $clog2(DEAD_TIME + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_DEAD  = 2'd2;

  logic [1:0]        r_state;
  logic [7:0]        r_lines;
  logic [LEN_W-1:0]  r_cnt;
  logic [DEAD_W-1:0] r_dead;
  logic              r_ready;
  logic              r_done;
  logic              r_aborted;
  logic              w_accept;

  // Line vector layout: bit 2*target is Up, bit 2*target+1 is Down.
  function automatic logic [7:0] line_sel(input logic [1:0] tgt, input logic dir);
    logic [7:0] v;
    v = 8'd0;
    v[{tgt, ~dir}] = 1'b1;
    return v;
  endfunction

  assign w_accept = cmd_valid & r_ready;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state   <= S_IDLE;
      r_lines   <= 8'd0;
      r_cnt     <= '0;
      r_dead    <= '0;
      r_ready   <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          r_lines <= 8'd0;
          if (w_accept) begin
            if (cmd_len != '0) begin
              r_state <= S_DRIVE;
              r_ready <= 1'b0;
              r_lines <= line_sel(cmd_target, cmd_dir);
              r_cnt   <= cmd_len;
            end else begin
              // Zero-length command completes at once with no dead-time.
              r_done  <= 1'b1;
            end
          end
        end
        S_DRIVE: begin
          r_ready <= 1'b0;
          if (r_cnt == LEN_W'(1)) begin
            // Final cycle wins over a coincident abort: the drive completed.
            r_lines <= 8'd0;
            r_done  <= 1'b1;
            r_state <= S_DEAD;
            r_dead  <= DEAD_W'(DEAD_TIME);
          end else if (abort) begin
            r_lines   <= 8'd0;
            r_done    <= 1'b1;
            r_aborted <= 1'b1;
            r_state   <= S_DEAD;
            r_dead    <= DEAD_W'(DEAD_TIME);
          end else begin
            r_cnt <= r_cnt - LEN_W'(1);
          end
        end
        S_DEAD: begin
          r_lines <= 8'd0;
          r_ready <= 1'b0;
          if (r_dead == DEAD_W'(1)) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end else begin
            r_dead <= r_dead - DEAD_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_lines <= 8'd0;
          r_ready <= 1'b0;
          r_cnt   <= '0;
          r_dead  <= '0;
        end
      endcase
    end
  end

  assign ready_out          = r_ready;
  assign done               = r_done;
  assign aborted            = r_aborted;
  assign DRV_Up_Out         = r_lines[0];
  assign DRV_Down_Out       = r_lines[1];
  assign PSG_Front_Up_Out   = r_lines[2];
  assign PSG_Front_Down_Out = r_lines[3];
  assign PSG_BackL_Up_Out   = r_lines[4];
  assign PSG_BackL_Down_Out = r_lines[5];
  assign PSG_BackR_Up_Out   = r_lines[6];
  assign PSG_BackR_Down_Out = r_lines[7];

endmodule

// File: tb/tb_actuator_trigger_sequencer.sv
// Scoreboard bench for actuator_trigger_sequencer: commands push predicted
// drive windows and completions; a negedge monitor compares every cycle.
module tb_actuator_trigger_sequencer;

  localparam int LEN_W = 16;
  localparam int DEAD  = 32;

  logic             Clk = 1'b0;
  logic             Reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [1:0]       cmd_target = 2'd0;
  logic             cmd_dir = 1'b0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             abort = 1'b0;
  logic             ready_out, done, aborted;
  logic             DRV_Up_Out, DRV_Down_Out, PSG_Front_Up_Out, PSG_Front_Down_Out;
  logic             PSG_BackL_Up_Out, PSG_BackL_Down_Out, PSG_BackR_Up_Out, PSG_BackR_Down_Out;
  logic [7:0]       drv_vec;

  actuator_trigger_sequencer #(.LEN_W(LEN_W), .DEAD_TIME(DEAD)) dut (
    .Clk(Clk), .Reset(Reset), .cmd_valid(cmd_valid), .cmd_target(cmd_target),
    .cmd_dir(cmd_dir), .cmd_len(cmd_len), .abort(abort), .ready_out(ready_out),
    .DRV_Up_Out(DRV_Up_Out), .DRV_Down_Out(DRV_Down_Out),
    .PSG_Front_Up_Out(PSG_Front_Up_Out), .PSG_Front_Down_Out(PSG_Front_Down_Out),
    .PSG_BackL_Up_Out(PSG_BackL_Up_Out), .PSG_BackL_Down_Out(PSG_BackL_Down_Out),
    .PSG_BackR_Up_Out(PSG_BackR_Up_Out), .PSG_BackR_Down_Out(PSG_BackR_Down_Out),
    .done(done), .aborted(aborted)
  );

  assign drv_vec = {PSG_BackR_Down_Out, PSG_BackR_Up_Out, PSG_BackL_Down_Out, PSG_BackL_Up_Out,
                    PSG_Front_Down_Out, PSG_Front_Up_Out, DRV_Down_Out, DRV_Up_Out};

  always #5 Clk = ~Clk;

  // cyc = index of the most recent rising edge; stable when read at negedge.
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int a;     // acceptance edge; line high from cycle a
    int e;     // cycle in which done is expected (line low from here)
    int len;
    int line;
    bit ab;
  } ent_t;

  ent_t sb[$];
  int   total = 0, bad = 0;
  int   free_at = 0, busy_until = 0, last_a = 0, last_e = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor
  int         m_n;
  logic [7:0] m_ed;
  logic       m_er;
  ent_t       m_f;
  always @(negedge Clk) begin
    if (mon_en) begin
      m_n  = cyc;
      m_ed = 8'd0;
      m_er = (m_n >= busy_until);
      if (sb.size() > 0) begin
        m_f = sb[0];
        if (m_f.len > 0 && m_n >= m_f.a && m_n < m_f.e) m_ed = 8'b1 << m_f.line;
        if (m_f.len > 0 && m_n >= m_f.a && m_n < m_f.e + DEAD) m_er = 1'b0;
      end
      chk("drive_lines", drv_vec, m_ed);
      chk("one_hot", ($countones(drv_vec) <= 1), 1);
      chk("ready_out", ready_out, m_er);
      if (done === 1'b1 || (sb.size() > 0 && m_n == sb[0].e)) begin
        if (sb.size() == 0) begin
          chk("spurious_done", done, 0);
        end else begin
          m_f = sb.pop_front();
          chk("done_pulse", done, 1);
          chk("done_time", m_n, m_f.e);
          chk("aborted_flag", aborted, m_f.ab);
          if (m_f.len > 0) busy_until = m_f.e + DEAD;
        end
      end else begin
        chk("aborted_idle", aborted, 0);
      end
    end
  end

  // Call at a negedge. k = drive cycle (1-based) in which abort is raised, 0 = none.
  task automatic issue(input int tgt, input int dir, input int len, input int k);
    ent_t en;
    int   a;
    cmd_target = tgt[1:0];
    cmd_dir    = dir[0];
    cmd_len    = len[LEN_W-1:0];
    cmd_valid  = 1'b1;
    a = (cyc + 1 > free_at) ? cyc + 1 : free_at;
    en.a    = a;
    en.len  = len;
    en.line = 2 * tgt + ((dir != 0) ? 0 : 1);
    if (len == 0) begin
      en.e = a; en.ab = 1'b0;
    end else if (k > 0 && k < len) begin
      en.e = a + k; en.ab = 1'b1;
    end else begin
      en.e = a + len; en.ab = 1'b0;
    end
    sb.push_back(en);
    free_at = (len == 0) ? a + 1 : en.e + DEAD + 1;
    last_a  = a;
    last_e  = en.e;
    while (cyc < a) @(negedge Clk);
    cmd_valid = 1'b0;
    if (k > 0) begin
      while (cyc < a + k - 1) @(negedge Clk);
      abort = 1'b1;
      @(negedge Clk);
      abort = 1'b0;
    end
  endtask

  task automatic release_reset();
    @(negedge Clk);
    Reset = 1'b1;
    free_at = cyc + 2;
    busy_until = 0;
    @(negedge Clk);
    chk("rst_ready", ready_out, 1);
    chk("rst_drive", drv_vec, 0);
    chk("rst_done", {done, aborted}, 0);
    mon_en = 1'b1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int len, k, r;
    repeat (3) @(negedge Clk);
    release_reset();

    @(negedge Clk);
    issue(2, 1, 5, 0);

    // abort in DEAD and in IDLE must have no effect
    while (cyc < last_e + 1) @(negedge Clk);
    abort = 1'b1; @(negedge Clk); abort = 1'b0;
    while (cyc < free_at - 1) @(negedge Clk);
    abort = 1'b1; @(negedge Clk); abort = 1'b0;

    issue(0, 0, 3, 0);
    issue(1, 1, 4, 0);

    issue(3, 0, 100, 10);
    issue(3, 0, 7, 7);
    issue(0, 1, 0, 0);
    issue(1, 0, 0, 0);
    issue(1, 0, 65535, 300);

    // reset in drive cycle 20 of a 50-cycle drive
    issue(2, 0, 50, 0);
    while (cyc < last_a + 19) @(negedge Clk);
    mon_en = 1'b0;
    #1 Reset = 1'b0;
    #1;
    chk("async_rst_drive", drv_vec, 0);
    chk("async_rst_done", {done, aborted}, 0);
    sb.delete();
    repeat (3) @(negedge Clk);
    release_reset();
    issue(3, 1, 6, 0);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge Clk);
      r = $urandom_range(0, 9);
      len = (r == 0) ? 0 : (r == 1) ? 1 : (r == 2) ? 2 : $urandom_range(3, 24);
      k = (len > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, len) : 0;
      issue($urandom_range(0, 3), $urandom_range(0, 1), len, k);
    end

    while (cyc < free_at + 2) @(negedge Clk);
    chk("scoreboard_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
